// File: rtl/spi_host_regs_if.sv
// Request/response port of spi_host_regs: one single-register SPI read or write per request.
interface spi_host_regs_if;
    logic       req_valid;
    logic       req_ready;
    logic       req_write;
    logic [6:0] req_addr;
    logic [7:0] req_wdata;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;

    // Requester side
    modport master (
        output req_valid, req_write, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata
    );

    // SPI host side
    modport slave (
        input  req_valid, req_write, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/spi_host_regs.sv
// SPI initiator (mode 0) for single-register access to the board register controller.
// Each request is a command frame {~write, addr} followed by a data frame (wdata or 0x00),
// separated by a chip-select-high gap; the byte shifted in during the data frame is returned.
// Optional feature macro SPI_HOST_LOOPBACK_EN: receive shifter samples the internal mosi
// instead of the miso pin; pin behaviour is unchanged.
module spi_host_regs #(
    parameter int unsigned CLK_DIV    = 2,
    parameter int unsigned GAP_CYCLES = 4
) (
    input  logic            clk,
    input  logic            rst,
    spi_host_regs_if.slave  bus,
    output logic            sclk,
    output logic            cs_n,
    output logic            mosi,
    input  logic            miso
);
    localparam int unsigned CNT_MAX = (CLK_DIV > GAP_CYCLES) ? CLK_DIV : GAP_CYCLES;
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int unsigned HP_W    = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT,
        ST_HOLD,
        ST_GAP,
        ST_DONE
    } state_t;

    state_t          state_q;
    logic            frame_q;
    logic [HP_W-1:0] hp_q;
    logic [CNT_W-1:0] div_q;
    logic [7:0]      tx_q;
    logic [7:0]      rx_q;
    logic            wr_q;
    logic [7:0]      wdata_q;
    logic            req_ready_q;
    logic            rsp_valid_q;
    logic [7:0]      rsp_rdata_q;
    logic            sclk_q;
    logic            cs_n_q;
    logic            mosi_q;

    logic            rx_bit;
    logic            div_last;
    logic            gap_last;

`ifdef SPI_HOST_LOOPBACK_EN
    // Loopback: receive what we transmit; the pin is intentionally left unobserved
    logic unused_miso;
    assign unused_miso = miso;
    assign rx_bit      = mosi_q;
`else
    assign rx_bit      = miso;
`endif

    assign div_last = (div_q == CNT_W'(CLK_DIV - 1));
    assign gap_last = (div_q == CNT_W'(GAP_CYCLES - 1));

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign sclk          = sclk_q;
    assign cs_n          = cs_n_q;
    assign mosi          = mosi_q;

    // Transaction FSM with all pin and handshake outputs registered
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            frame_q     <= 1'b0;
            hp_q        <= '0;
            div_q       <= '0;
            tx_q        <= 8'h00;
            rx_q        <= 8'h00;
            wr_q        <= 1'b0;
            wdata_q     <= 8'h00;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 8'h00;
            sclk_q      <= 1'b0;
            cs_n_q      <= 1'b1;
            mosi_q      <= 1'b0;
        end else begin
            rsp_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (bus.req_valid && req_ready_q) begin
                        wr_q        <= bus.req_write;
                        wdata_q     <= bus.req_wdata;
                        tx_q        <= {~bus.req_write, bus.req_addr};
                        mosi_q      <= ~bus.req_write;
                        cs_n_q      <= 1'b0;
                        sclk_q      <= 1'b0;
                        frame_q     <= 1'b0;
                        div_q       <= '0;
                        hp_q        <= '0;
                        req_ready_q <= 1'b0;
                        state_q     <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (div_last) begin
                        div_q   <= '0;
                        hp_q    <= '0;
                        state_q <= ST_SHIFT;
                    end else begin
                        div_q <= div_q + CNT_W'(1);
                    end
                end
                ST_SHIFT: begin
                    if (div_last) begin
                        div_q  <= '0;
                        sclk_q <= ~sclk_q;
                        if (!sclk_q) begin
                            rx_q <= {rx_q[6:0], rx_bit};
                        end else if (hp_q != HP_W'(15)) begin
                            mosi_q <= tx_q[6];
                            tx_q   <= {tx_q[6:0], 1'b0};
                        end
                        if (hp_q == HP_W'(15)) begin
                            state_q <= ST_HOLD;
                        end
                        hp_q <= hp_q + HP_W'(1);
                    end else begin
                        div_q <= div_q + CNT_W'(1);
                    end
                end
                ST_HOLD: begin
                    if (div_last) begin
                        div_q   <= '0;
                        cs_n_q  <= 1'b1;
                        mosi_q  <= 1'b0;
                        state_q <= frame_q ? ST_DONE : ST_GAP;
                    end else begin
                        div_q <= div_q + CNT_W'(1);
                    end
                end
                ST_GAP: begin
                    if (gap_last) begin
                        div_q   <= '0;
                        frame_q <= 1'b1;
                        tx_q    <= wr_q ? wdata_q : 8'h00;
                        mosi_q  <= wr_q & wdata_q[7];
                        cs_n_q  <= 1'b0;
                        state_q <= ST_SETUP;
                    end else begin
                        div_q <= div_q + CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    rsp_valid_q <= 1'b1;
                    rsp_rdata_q <= rx_q;
                    req_ready_q <= 1'b1;
                    state_q     <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end
endmodule
